money_collect: RTL and testbench
================================

MONEY_COLLECT -- requirements
Module: money_collect

Interface
REQ-001 Parameter PRICE0, default 8'd65, price of item 0 in cents.
REQ-002 Parameter PRICE1, default 8'd100, price of item 1 in cents.
REQ-003 Parameter PRICE2, default 8'd135, price of item 2 in cents.
REQ-004 Parameter PRICE3, default 8'd150, price of item 3 in cents.
REQ-005 The block SHALL provide these ports:
  - clock  in  1  sole clock; all state changes on its rising edge.
  - reset_n  in  1  asynchronous, active-low reset.
  - coin_in  in  4  one-cycle coin pulse: [3]=50c, [2]=25c, [1]=10c, [0]=5c.
  - item_sel  in  2  item index, sampled when select_valid=1.
  - select_valid  in  1  one-cycle item-selection strobe.
  - cancel  in  1  one-cycle refund request.
  - done_changing  in  1  completion flag from the downstream change dispenser.
  - done_money_in  out  1  payment complete; change_back valid.
  - change_back  out  8  change owed in cents.
  - dispense  out  1  one-cycle vend pulse.
  - item_out  out  2  latched item index.
  - total  out  8  current credit in cents.
  - coin_reject  out  1  one-cycle pulse when a coin is refused.

Function
REQ-006 The FSM SHALL have states IDLE, ARMED, PAY and CLEAR, encoded as a registered state.
REQ-007 In IDLE and ARMED, a valid coin (exactly one coin_in bit set) SHALL add 50/25/10/5 to total at the same edge.
REQ-008 A coin_in value with more than one bit set SHALL add nothing and SHALL pulse coin_reject for one cycle.
REQ-009 A coin that would make total exceed 255 SHALL add nothing and SHALL pulse coin_reject for one cycle.
REQ-010 In PAY and CLEAR, any nonzero coin_in SHALL add nothing and SHALL pulse coin_reject for one cycle.
REQ-011 In IDLE, select_valid SHALL latch item_sel into item_out and move to ARMED.
REQ-012 In ARMED, select_valid SHALL overwrite item_out and stay in ARMED.
REQ-013 In ARMED, at an edge where the registered total >= PRICE[item_out], the block SHALL do all of the following at that edge:
  - move to PAY;
  - load change_back = total - price;
  - pulse dispense for one cycle.
REQ-014 Latency: a coin at edge N that reaches the price SHALL cause done_money_in=1 and dispense=1 after edge N+1.
REQ-015 In IDLE or ARMED, cancel with total > 0 SHALL move to PAY with change_back = total and no dispense pulse.
REQ-016 In IDLE or ARMED, cancel with total == 0 SHALL return to IDLE and clear item_out to 0.
REQ-017 When cancel and select_valid arrive in the same cycle, cancel SHALL take priority and the selection SHALL be ignored.
REQ-018 When cancel and a valid coin arrive in the same cycle, the coin SHALL be accepted and included in the refund.
REQ-019 When a coin and select_valid arrive in the same cycle, both SHALL take effect; the price comparison uses the updated total at the next edge.
REQ-020 done_money_in SHALL be 1 exactly while in PAY.
REQ-021 change_back SHALL be held constant throughout PAY.
REQ-022 In PAY, done_changing SHALL be treated as asserted only when it equals logic 1; X or Z SHALL count as not asserted.
REQ-023 In PAY, asserted done_changing SHALL move the FSM to CLEAR.
REQ-024 In CLEAR (one cycle), the block SHALL drive done_money_in=0, set total=0, change_back=0 and item_out=0, then move to IDLE.
REQ-025 In PAY, select_valid and cancel SHALL be ignored.
REQ-026 PAY SHALL have no timeout; the FSM remains there until done_changing is asserted.
REQ-027 All arithmetic SHALL be unsigned 8-bit; subtraction occurs only when total >= price, so no underflow is possible.

Reset
REQ-028 When reset_n=0, the block SHALL immediately, independent of clock:
  - force state=IDLE;
  - drive total=0, change_back=0, item_out=0;
  - drive done_money_in=0, dispense=0, coin_reject=0.
REQ-029 A reset mid-transaction, including during PAY, SHALL discard all credit with no refund.
REQ-030 After reset_n rises, the block SHALL accept a coin on the first rising clock edge.

Verification
REQ-031 Item 0; coins 25, 25, 10, 10 -> total=70; one cycle later done_money_in=1, change_back=5, dispense pulse; done_changing=1 -> CLEAR, then IDLE with total=0.
REQ-032 Item 1; coins 50, 50 (exact) -> change_back=0, dispense=1; PAY held until done_changing=1.
REQ-033 Coins 25, 10 then cancel -> PAY with change_back=35, no dispense; coin_in=4'b0011 -> coin_reject, total unchanged.
REQ-034 Credit at 240; coin 25 -> coin_reject, total=240; a coin arriving during PAY -> coin_reject.
REQ-035 Cancel+select in the same cycle with total=0 -> IDLE, item_out=0; coin 10 + cancel in the same cycle -> change_back=10.
REQ-036 Drop reset_n during PAY with change_back=40 -> all outputs 0 asynchronously and state=IDLE.

Source files
------------

// File: rtl/money_collect.sv
// Vending-machine payment collector: accumulates coin credit, vends once the
// selected item's price is covered, and hands the change amount downstream.
module money_collect #(
    parameter logic [7:0] PRICE0 = 8'd65,
    parameter logic [7:0] PRICE1 = 8'd100,
    parameter logic [7:0] PRICE2 = 8'd135,
    parameter logic [7:0] PRICE3 = 8'd150
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] coin_in,
    input  logic [1:0] item_sel,
    input  logic       select_valid,
    input  logic       cancel,
    input  logic       done_changing,
    output logic       done_money_in,
    output logic [7:0] change_back,
    output logic       dispense,
    output logic [1:0] item_out,
    output logic [7:0] total,
    output logic       coin_reject
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PAY   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] total_q, total_d;
    logic [7:0] change_q, change_d;
    logic [1:0] item_q, item_d;
    logic       done_q, done_d;
    logic       disp_q, disp_d;
    logic       rej_q, rej_d;

    logic [7:0] coin_val_s;
    logic [7:0] price_s;
    logic [8:0] sum_s;
    logic       coin_any_s;
    logic       coin_ok_s;
    logic [7:0] credit_s;

    // Multi-bit coin patterns map to zero so they are never credited.
    function automatic logic [7:0] coin_value(input logic [3:0] c);
        logic [7:0] v;
        case (c)
            4'b1000: v = 8'd50;
            4'b0100: v = 8'd25;
            4'b0010: v = 8'd10;
            4'b0001: v = 8'd5;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] price_of(input logic [1:0] idx);
        logic [7:0] p;
        case (idx)
            2'd0:    p = PRICE0;
            2'd1:    p = PRICE1;
            2'd2:    p = PRICE2;
            2'd3:    p = PRICE3;
            default: p = PRICE0;
        endcase
        return p;
    endfunction

    // Coin decode and the credit that would result from accepting it.
    always_comb begin
        coin_val_s = coin_value(coin_in);
        coin_any_s = |coin_in;
        price_s    = price_of(item_q);
        sum_s      = {1'b0, total_q} + {1'b0, coin_val_s};
        coin_ok_s  = (coin_val_s != 8'd0) && !sum_s[8];
        if (coin_ok_s) begin
            credit_s = sum_s[7:0];
        end else begin
            credit_s = total_q;
        end
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        change_d = change_q;
        item_d   = item_q;
        disp_d   = 1'b0;
        rej_d    = 1'b0;
        case (state_q)
            IDLE, ARMED: begin
                // The vend edge uses the registered credit; a coin landing on
                // that same edge is refused so it cannot vanish from the change.
                if ((state_q == ARMED) && (total_q >= price_s)) begin
                    state_d  = PAY;
                    change_d = total_q - price_s;
                    disp_d   = 1'b1;
                    rej_d    = coin_any_s;
                end else begin
                    total_d = credit_s;
                    rej_d   = coin_any_s && !coin_ok_s;
                    if (cancel) begin
                        if (credit_s != 8'd0) begin
                            state_d  = PAY;
                            change_d = credit_s;
                        end else begin
                            state_d = IDLE;
                            item_d  = 2'd0;
                        end
                    end else if (select_valid) begin
                        item_d  = item_sel;
                        state_d = ARMED;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            PAY: begin
                rej_d = coin_any_s;
                if (done_changing == 1'b1) begin
                    state_d  = CLEAR;
                    total_d  = 8'd0;
                    change_d = 8'd0;
                    item_d   = 2'd0;
                end else begin
                    state_d = PAY;
                end
            end
            CLEAR: begin
                rej_d   = coin_any_s;
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                total_d  = 8'd0;
                change_d = 8'd0;
                item_d   = 2'd0;
            end
        endcase
        done_d = (state_d == PAY);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            total_q  <= 8'd0;
            change_q <= 8'd0;
            item_q   <= 2'd0;
            done_q   <= 1'b0;
            disp_q   <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            change_q <= change_d;
            item_q   <= item_d;
            done_q   <= done_d;
            disp_q   <= disp_d;
            rej_q    <= rej_d;
        end
    end

    assign done_money_in = done_q;
    assign change_back   = change_q;
    assign dispense      = disp_q;
    assign item_out      = item_q;
    assign total         = total_q;
    assign coin_reject   = rej_q;

endmodule

// File: tb/tb_money_collect.sv
// Directed bench for money_collect: a transaction-level model is checked
// against the DUT every cycle, plus literal expectations from the scenarios.
`timescale 1ns/1ps
module tb_money_collect;

    logic       clock;
    logic       reset_n;
    logic [3:0] coin_in;
    logic [1:0] item_sel;
    logic       select_valid;
    logic       cancel;
    logic       done_changing;
    logic       done_money_in;
    logic [7:0] change_back;
    logic       dispense;
    logic [1:0] item_out;
    logic [7:0] total;
    logic       coin_reject;

    int n_checks = 0;
    int n_fail   = 0;

    money_collect dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .coin_in      (coin_in),
        .item_sel     (item_sel),
        .select_valid (select_valid),
        .cancel       (cancel),
        .done_changing(done_changing),
        .done_money_in(done_money_in),
        .change_back  (change_back),
        .dispense     (dispense),
        .item_out     (item_out),
        .total        (total),
        .coin_reject  (coin_reject)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: "shopping" (credit accumulating, optionally with a
    // chosen item), "paying" (waiting for change), "clearing" (one wipe cycle).
    localparam int SHOP = 0, PAYING = 1, CLEARING = 2;
    int m_phase, m_credit, m_item, m_change;
    bit m_chosen, m_disp, m_rej;

    function automatic int cost(input int idx);
        int table_c[4] = '{65, 100, 135, 150};
        return table_c[idx];
    endfunction

    function automatic int coin_cents(input logic [3:0] c);
        if (c == 4'b1000) return 50;
        if (c == 4'b0100) return 25;
        if (c == 4'b0010) return 10;
        if (c == 4'b0001) return 5;
        return 0;
    endfunction

    task automatic model_advance();
        int v;
        v = coin_cents(coin_in);
        m_disp = 1'b0;
        m_rej  = 1'b0;
        if (m_phase == SHOP) begin
            if (m_chosen && (m_credit >= cost(m_item))) begin
                m_change = m_credit - cost(m_item);
                m_disp   = 1'b1;
                m_rej    = (coin_in != 4'd0);
                m_phase  = PAYING;
            end else begin
                if (coin_in != 4'd0) begin
                    if ((v == 0) || (m_credit + v > 255)) m_rej = 1'b1;
                    else m_credit = m_credit + v;
                end
                if (cancel) begin
                    if (m_credit > 0) begin
                        m_change = m_credit;
                        m_phase  = PAYING;
                    end else begin
                        m_item   = 0;
                        m_chosen = 1'b0;
                    end
                end else if (select_valid) begin
                    m_item   = item_sel;
                    m_chosen = 1'b1;
                end
            end
        end else if (m_phase == PAYING) begin
            m_rej = (coin_in != 4'd0);
            if (done_changing === 1'b1) begin
                m_credit = 0;
                m_change = 0;
                m_item   = 0;
                m_phase  = CLEARING;
            end
        end else begin
            m_rej    = (coin_in != 4'd0);
            m_chosen = 1'b0;
            m_phase  = SHOP;
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = SHOP; m_credit = 0; m_item = 0; m_change = 0;
            m_chosen = 1'b0; m_disp = 1'b0; m_rej = 1'b0;
        end else begin
            model_advance();
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            check("done_money_in", int'(done_money_in), int'(m_phase == PAYING));
            check("change_back", int'(change_back), m_change);
            check("dispense", int'(dispense), int'(m_disp));
            check("item_out", int'(item_out), m_item);
            check("total", int'(total), m_credit);
            check("coin_reject", int'(coin_reject), int'(m_rej));
        end
    end

    task automatic step(input logic [3:0] c, input logic sv, input logic [1:0] is,
                        input logic cn, input logic dc);
        coin_in = c; select_valid = sv; item_sel = is; cancel = cn; done_changing = dc;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; coin_in = 4'd0; item_sel = 2'd0;
        select_valid = 1'b0; cancel = 1'b0; done_changing = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_total", int'(total), 0);
        check("reset_done", int'(done_money_in), 0);
        reset_n = 1'b1;
        idle(1);

        // Item 0, coins 25,25,10,10 -> 70, change 5.
        step(4'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 2'd0, 1'b0, 1'b0);
        check("s1_total70", int'(total), 70);
        check("s1_no_early_done", int'(done_money_in), 0);
        idle(1);
        check("s1_done", int'(done_money_in), 1);
        check("s1_change5", int'(change_back), 5);
        check("s1_dispense", int'(dispense), 1);
        step(4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        check("s1_clear_done", int'(done_money_in), 0);
        check("s1_clear_total", int'(total), 0);
        idle(1);

        // Item 1, exact 100; PAY held without done_changing, X does not count.
        step(4'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(1);
        check("s2_change0", int'(change_back), 0);
        check("s2_dispense", int'(dispense), 1);
        idle(3);
        step(4'd0, 1'b1, 2'd2, 1'b1, 1'bx);
        check("s2_pay_held", int'(done_money_in), 1);
        check("s2_item_kept", int'(item_out), 1);
        step(4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        idle(1);

        // Coins 25,10, multi-bit reject, cancel -> refund 35.
        step(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 2'd0, 1'b0, 1'b0);
        check("s3_multibit_reject", int'(coin_reject), 1);
        check("s3_total35", int'(total), 35);
        step(4'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        check("s3_refund35", int'(change_back), 35);
        check("s3_no_dispense", int'(dispense), 0);
        check("s3_done", int'(done_money_in), 1);
        step(4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        idle(1);

        // Credit to 240, overflow reject, item 3 -> change 90, coin in PAY.
        for (int i = 0; i < 4; i++) step(4'b1000, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        check("s4_total240", int'(total), 240);
        step(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        check("s4_overflow_reject", int'(coin_reject), 1);
        check("s4_total_kept", int'(total), 240);
        step(4'd0, 1'b1, 2'd3, 1'b0, 1'b0);
        idle(1);
        check("s4_change90", int'(change_back), 90);
        step(4'b1000, 1'b0, 2'd0, 1'b0, 1'b0);
        check("s4_pay_reject", int'(coin_reject), 1);
        check("s4_total_in_pay", int'(total), 240);
        step(4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        idle(1);

        // Cancel+select at zero credit; coin+cancel refunds the coin.
        step(4'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        check("s5_item2", int'(item_out), 2);
        step(4'd0, 1'b1, 2'd1, 1'b1, 1'b0);
        check("s5_item_cleared", int'(item_out), 0);
        check("s5_not_paying", int'(done_money_in), 0);
        step(4'b0010, 1'b0, 2'd0, 1'b1, 1'b0);
        check("s5_refund10", int'(change_back), 10);
        step(4'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        idle(1);

        // Reset during PAY with change 40, then a coin on the first edge.
        step(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'd0, 1'b1, 2'd3, 1'b1, 1'b0);
        check("s6_change40", int'(change_back), 40);
        #2 reset_n = 1'b0;
        #1;
        check("s6_rst_done", int'(done_money_in), 0);
        check("s6_rst_change", int'(change_back), 0);
        check("s6_rst_total", int'(total), 0);
        check("s6_rst_item", int'(item_out), 0);
        check("s6_rst_disp_rej", int'(dispense) + int'(coin_reject), 0);
        @(negedge clock);
        reset_n = 1'b1;
        step(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        check("s6_first_coin", int'(total), 5);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
